// File: rtl/input_peri_dbnc.sv
// ---------------------------------------------------------------------------
// input_peri_dbnc
//   Memory-mapped input peripheral for the LSU I/O bus: a bank of switches
//   and a bank of debounced push buttons. Every raw input passes through a
//   two-flop synchroniser. Sticky change/press flags are write-one-to-clear.
//   Reads are combinational from addr and show the pre-write register state.
//
//   Register map (byte offsets, unlisted offsets read 0 and ignore writes):
//     0x00 SW      RO   synchronised switch levels
//     0x04 SW_CHG  W1C  switch bit changed
//     0x10 BTN     RO   debounced button levels
//     0x14 BTN_PRS W1C  debounced press (0->1) seen
//     0x18 BTN_IE  RW   per-button press interrupt enable
//
//   Optional feature macro: INPUT_PERI_IRQ_EN
//     defined   : BTN_IE register and registered level irq are built.
//     undefined : no enable flops, 0x18 reads 0, irq tied low.
//
// Ports
//   clk     system clock, all state on the rising edge
//   rst     asynchronous active-high reset
//   addr    byte offset within the peripheral window
//   we      one-cycle write strobe
//   wdata   write data
//   io_sw   raw switch inputs (asynchronous)
//   io_btn  raw button inputs (asynchronous, bouncing, 1 = pressed)
//   rdata   combinational read data
//   irq     registered level interrupt
// ---------------------------------------------------------------------------
module input_peri_dbnc #(
  parameter int SW_W      = 32,
  parameter int BTN_N     = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       addr,
  input  logic             we,
  input  logic [31:0]      wdata,
  input  logic [SW_W-1:0]  io_sw,
  input  logic [BTN_N-1:0] io_btn,
  output logic [31:0]      rdata,
  output logic             irq
);

  localparam int              CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  localparam logic [7:0] ADDR_SW     = 8'h00;
  localparam logic [7:0] ADDR_SW_CHG = 8'h04;
  localparam logic [7:0] ADDR_BTN    = 8'h10;
  localparam logic [7:0] ADDR_PRS    = 8'h14;
  localparam logic [7:0] ADDR_IE     = 8'h18;

  function automatic logic [31:0] zext_sw(input logic [SW_W-1:0] v);
    zext_sw = '0;
    zext_sw[SW_W-1:0] = v;
  endfunction

  function automatic logic [31:0] zext_btn(input logic [BTN_N-1:0] v);
    zext_btn = '0;
    zext_btn[BTN_N-1:0] = v;
  endfunction

  logic [SW_W-1:0]  sw_p0, sw_p1, sw_chg, sw_chg_nx, sw_clr;
  logic [BTN_N-1:0] btn_p0, btn_p1;
  logic [BTN_N-1:0] btn_stable, stable_nx;
  logic [BTN_N-1:0] btn_prs, prs_nx, prs_set, prs_clr;
  logic [CNT_W-1:0] cnt    [BTN_N];
  logic [CNT_W-1:0] cnt_nx [BTN_N];
  logic [31:0]      ie_rd;

  // Stage p0 -> p1: two-flop synchronisers (p1 is the usable level)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_p0  <= '0;
      sw_p1  <= '0;
      btn_p0 <= '0;
      btn_p1 <= '0;
    end else begin
      sw_p0  <= io_sw;
      sw_p1  <= sw_p0;
      btn_p0 <= io_btn;
      btn_p1 <= btn_p0;
    end
  end

  // Write-one-to-clear masks, only for a write hitting the flag register
  always_comb begin
    sw_clr  = (we && addr == ADDR_SW_CHG) ? wdata[SW_W-1:0]  : '0;
    prs_clr = (we && addr == ADDR_PRS)    ? wdata[BTN_N-1:0] : '0;
  end

  // A switch change is flagged on the same edge the p1 level takes it.
  // Set is OR-ed after the clear so a coincident set wins.
  always_comb begin
    sw_chg_nx = (sw_chg & ~sw_clr) | (sw_p0 ^ sw_p1);
  end

  // Debounce: the counter counts consecutive cycles where the synced level
  // disagrees with the stable level; any agreement restarts the window.
  always_comb begin
    stable_nx = btn_stable;
    prs_set   = '0;
    for (int i = 0; i < BTN_N; i++) begin
      cnt_nx[i] = '0;
      if (btn_p1[i] != btn_stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_nx[i] = btn_p1[i];
          prs_set[i]   = btn_p1[i];
        end else begin
          cnt_nx[i] = cnt[i] + 1'b1;
        end
      end
    end
    prs_nx = (btn_prs & ~prs_clr) | prs_set;
  end

  // Stage p1 -> p2: debounced state and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_chg     <= '0;
      btn_stable <= '0;
      btn_prs    <= '0;
      for (int i = 0; i < BTN_N; i++) cnt[i] <= '0;
    end else begin
      sw_chg     <= sw_chg_nx;
      btn_stable <= stable_nx;
      btn_prs    <= prs_nx;
      for (int i = 0; i < BTN_N; i++) cnt[i] <= cnt_nx[i];
    end
  end

`ifdef INPUT_PERI_IRQ_EN
  logic [BTN_N-1:0] btn_ie, ie_nx;
  logic             irq_q;

  always_comb begin
    ie_nx = (we && addr == ADDR_IE) ? wdata[BTN_N-1:0] : btn_ie;
  end

  // irq looks at next-state flags and enables so it tracks them with one
  // register of delay and drops on the edge the last enabled flag clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_ie <= '0;
      irq_q  <= 1'b0;
    end else begin
      btn_ie <= ie_nx;
      irq_q  <= |(prs_nx & ie_nx);
    end
  end

  assign irq   = irq_q;
  assign ie_rd = zext_btn(btn_ie);
`else
  assign irq   = 1'b0;
  assign ie_rd = '0;
`endif

  always_comb begin
    unique case (addr)
      ADDR_SW:     rdata = zext_sw(sw_p1);
      ADDR_SW_CHG: rdata = zext_sw(sw_chg);
      ADDR_BTN:    rdata = zext_btn(btn_stable);
      ADDR_PRS:    rdata = zext_btn(btn_prs);
      ADDR_IE:     rdata = ie_rd;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_input_peri_dbnc.sv
module tb_input_peri_dbnc;

  localparam int SW_W = 32;
  localparam int BTN_N = 4;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] io_sw;
  logic [3:0]  io_btn;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  input_peri_dbnc #(.SW_W(SW_W), .BTN_N(BTN_N), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata),
    .io_sw(io_sw), .io_btn(io_btn), .rdata(rdata), .irq(irq)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference model: raw inputs appear two edges later; a button's level
  // flips once the synced value has disagreed with it for DB samples in a row.
  logic [31:0] m_sw_h [2];
  logic [31:0] m_sw_chg;
  logic [3:0]  m_btn_h [2];
  logic [3:0]  m_stable, m_prs, m_ie;
  int          m_run [4];
  logic        m_irq;

  task automatic model_reset();
    m_sw_h[0] = '0; m_sw_h[1] = '0; m_sw_chg = '0;
    m_btn_h[0] = '0; m_btn_h[1] = '0;
    m_stable = '0; m_prs = '0; m_ie = '0; m_irq = 1'b0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [31:0] clr_sw;
    logic [3:0]  clr_b, set;
    clr_sw = (we && addr == 8'h04) ? wdata : 32'h0;
    clr_b  = (we && addr == 8'h14) ? wdata[3:0] : 4'h0;
    set = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_btn_h[1][i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_stable[i] = m_btn_h[1][i];
          m_run[i] = 0;
          if (m_stable[i]) set[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_sw_chg = (m_sw_chg & ~clr_sw) | (m_sw_h[0] ^ m_sw_h[1]);
    m_sw_h[1] = m_sw_h[0];  m_sw_h[0] = io_sw;
    m_btn_h[1] = m_btn_h[0]; m_btn_h[0] = io_btn;
    m_prs = (m_prs & ~clr_b) | set;
`ifdef INPUT_PERI_IRQ_EN
    if (we && addr == 8'h18) m_ie = wdata[3:0];
    m_irq = |(m_prs & m_ie);
`else
    m_irq = 1'b0;
`endif
  endtask

  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    case (a)
      8'h00:   return m_sw_h[1];
      8'h04:   return m_sw_chg;
      8'h10:   return {28'h0, m_stable};
      8'h14:   return {28'h0, m_prs};
      8'h18:   return {28'h0, m_ie};
      default: return 32'h0;
    endcase
  endfunction

  logic [7:0] addr_tab [7] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1c};

  // Read every register back (combinationally) and compare against the model.
  task automatic sweep(input string tag);
    we = 1'b0;
    for (int j = 0; j < 7; j++) begin
      addr = addr_tab[j];
      #1;
      check($sformatf("%s@%02h", tag, addr_tab[j]), rdata, exp_rd(addr_tab[j]));
    end
    check({tag, ".irq"}, {31'h0, irq}, {31'h0, m_irq});
  endtask

  // Inputs are already driven; advance one edge with model and sweep.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk); #1;
    sweep(tag);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    we = 1'b0;
    for (int j = 0; j < n; j++) cycle(tag);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; io_sw = '0; io_btn = '0;
    model_reset();

    // reset held while inputs toggle: everything reads 0
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      io_sw = $urandom; io_btn = 4'($urandom);
      @(posedge clk); #1;
      sweep("rst_hold");
    end
    @(negedge clk);
    io_sw = '0; io_btn = '0;
    rst = 1'b0;
    idle(2, "rst_rel");

    // held press of btn0: visible after the sixth edge counting edge k
    io_btn = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      model_edge();
      @(posedge clk); #1;
      addr = 8'h10; #1;
      check($sformatf("lat_btn_e%0d", e), rdata, (e >= 6) ? 32'h1 : 32'h0);
      addr = 8'h14; #1;
      check($sformatf("lat_prs_e%0d", e), rdata, (e >= 6) ? 32'h1 : 32'h0);
      @(negedge clk);
    end

    // btn1 high for only 3 cycles: filtered out
    io_btn = 4'b0011;
    idle(3, "bounce_hi");
    io_btn = 4'b0001;
    idle(6, "bounce_lo");
    addr = 8'h10; #1; check("bounce_btn", rdata, 32'h1);
    addr = 8'h14; #1; check("bounce_prs", rdata, 32'h1);
    @(negedge clk);

    // release btn0 (no new flag), then press again with a W1C on landing edge
    io_btn = 4'b0000;
    idle(8, "release");
    addr = 8'h14; #1; check("release_prs", rdata, 32'h1);
    @(negedge clk);
    io_btn = 4'b0001;
    for (int e = 1; e <= 6; e++) begin
      if (e == 6) begin we = 1'b1; addr = 8'h14; wdata = 32'h1; end
      else we = 1'b0;
      cycle("collide");
    end
    addr = 8'h14; #1; check("collide_set_wins", rdata, 32'h1);
    @(negedge clk);
    we = 1'b1; addr = 8'h14; wdata = 32'h1;
    cycle("prs_clr");
    addr = 8'h14; #1; check("prs_cleared", rdata, 32'h0);
    @(negedge clk);

    // switch change: two edges to appear, flag alongside, partial W1C
    io_sw = 32'h8000_0001;
    idle(1, "sw_e1");
    addr = 8'h00; #1; check("sw_e1", rdata, 32'h0);
    @(negedge clk);
    idle(1, "sw_e2");
    addr = 8'h00; #1; check("sw_e2", rdata, 32'h8000_0001);
    addr = 8'h04; #1; check("sw_chg", rdata, 32'h8000_0001);
    @(negedge clk);
    we = 1'b1; addr = 8'h04; wdata = 32'h1;
    cycle("sw_w1c");
    addr = 8'h04; #1; check("sw_chg_w1c", rdata, 32'h8000_0000);
    @(negedge clk);

    // interrupt enable on btn2, press, then clear
    we = 1'b1; addr = 8'h18; wdata = 32'hFFFF_FFF4;
    cycle("ie_wr");
    io_btn = 4'b0101;
    idle(8, "irq_press");
    we = 1'b1; addr = 8'h14; wdata = 32'h4;
    cycle("irq_clr");
    idle(2, "irq_after");

    // randomized traffic with an asynchronous reset in the middle
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        #3 rst = 1'b1;
        model_reset();
        #1;
        addr = 8'h10; #1; check("arst_btn", rdata, 32'h0);
        addr = 8'h14; #1; check("arst_prs", rdata, 32'h0);
        check("arst_irq", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        sweep("arst_hold");
        @(negedge clk);
        rst = 1'b0;
      end
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) io_btn[b] = ~io_btn[b];
      if ($urandom_range(0, 15) == 0) io_sw = $urandom;
      we    = ($urandom_range(0, 3) == 0);
      addr  = addr_tab[$urandom_range(0, 6)];
      wdata = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
